// File: rtl/knn_cluster1_pkg.sv
// Shared types and constants for the knn_cluster1 datapath.
// The slot payload is sized for the widest legal product; narrower pipes use the low bits.
package knn_cluster1_pkg;

  localparam int unsigned MUL_MAX_STAGE = 6;
  localparam int unsigned MUL_MAX_P     = 64;

  typedef struct packed {
    logic                 valid;
    logic                 is_signed;
    logic [MUL_MAX_P-1:0] data;
  } mul_slot_t;

  function automatic bit mul_params_ok(int w0, int w1, int wd, int ns);
    return (w0 >= 2) && (w0 <= 32) && (w1 >= 2) && (w1 <= 32) &&
           (wd >= 1) && (wd <= 64) && (ns >= 1) && (ns <= int'(MUL_MAX_STAGE));
  endfunction

endpackage

// File: rtl/knn_cluster1_mul_pipe_slot.sv
// One pipeline slot: valid flag plus payload, loaded whenever the slot can take a beat.
// Payload only changes when a valid beat arrives, so an emptied slot keeps its last data.
module knn_cluster1_mul_pipe_slot
  import knn_cluster1_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      load,
  input  mul_slot_t d,
  output mul_slot_t q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q.valid <= d.valid;
      if (d.valid) begin
        q.is_signed <= d.is_signed;
        q.data      <= d.data;
      end
    end
  end

endmodule

// File: rtl/knn_cluster1_mul_pipe.sv
// Pipelined signed/unsigned integer multiplier with valid/ready at both ends.
// The product is formed before slot 0; later slots only carry it, collapsing bubbles.
module knn_cluster1_mul_pipe
  import knn_cluster1_pkg::*;
#(
  parameter int din0_WIDTH = 17,
  parameter int din1_WIDTH = 15,
  parameter int dout_WIDTH = 32,
  parameter int NUM_STAGE  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_signed,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout
);

  localparam int P = din0_WIDTH + din1_WIDTH;

  if (!mul_params_ok(din0_WIDTH, din1_WIDTH, dout_WIDTH, NUM_STAGE)) begin : g_bad_params
    $fatal(1, "knn_cluster1_mul_pipe: parameter out of range");
  end

  logic [P-1:0] a_ext;
  logic [P-1:0] b_ext;
  logic [P-1:0] prod;
  mul_slot_t    head;

  // P-bit modular product of extended operands is exact in both modes.
  always_comb begin
    a_ext = {{din1_WIDTH{in_signed & din0[din0_WIDTH-1]}}, din0};
    b_ext = {{din0_WIDTH{in_signed & din1[din1_WIDTH-1]}}, din1};
    prod  = a_ext * b_ext;
    head              = '0;
    head.valid        = in_valid;
    head.is_signed    = in_signed;
    head.data[P-1:0]  = prod;
  end

  mul_slot_t             slot_d [NUM_STAGE];
  mul_slot_t             slot_q [NUM_STAGE];
  logic [NUM_STAGE-1:0]  slot_valid;
  logic [NUM_STAGE-1:0]  adv;
  logic [NUM_STAGE-1:0]  take;
  logic                  downstream;

  for (genvar k = 0; k < NUM_STAGE; k++) begin : g_slot
    if (k == 0) begin : g_head
      assign slot_d[k] = head;
    end else begin : g_body
      assign slot_d[k] = slot_q[k-1];
    end

    knn_cluster1_mul_pipe_slot u_slot (
      .clk   (clk),
      .reset (reset),
      .load  (take[k]),
      .d     (slot_d[k]),
      .q     (slot_q[k])
    );

    assign slot_valid[k] = slot_q[k].valid;
  end

  // Walk from the output back to slot 0 so readiness ripples combinationally upstream.
  always_comb begin
    adv        = '0;
    take       = '0;
    downstream = out_ready;
    for (int unsigned i = 0; i < NUM_STAGE; i++) begin
      adv[NUM_STAGE-1-i]  = slot_valid[NUM_STAGE-1-i] & downstream;
      take[NUM_STAGE-1-i] = ~slot_valid[NUM_STAGE-1-i] | adv[NUM_STAGE-1-i];
      downstream          = take[NUM_STAGE-1-i];
    end
  end

  mul_slot_t last;
  logic      unused_data;

  assign last        = slot_q[NUM_STAGE-1];
  assign unused_data = ^last.data;
  assign in_ready    = take[0];
  assign out_valid   = last.valid;

  if (dout_WIDTH <= P) begin : g_trunc
    assign dout = last.data[dout_WIDTH-1:0];
  end else begin : g_extend
    assign dout = {{(dout_WIDTH-P){last.is_signed & last.data[P-1]}}, last.data[P-1:0]};
  end

endmodule

// File: tb/tb_knn_cluster1_mul_pipe.sv
// Bench for knn_cluster1_mul_pipe: five parameter variants share one stimulus stream,
// each with its own scoreboard fed on acceptance and drained on handshake.
module tb_knn_cluster1_mul_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_signed;
  logic        out_ready;
  logic [16:0] din0;
  logic [14:0] din1;

  logic [4:0]  ir_v;
  logic [4:0]  ov_v;
  logic [63:0] dout_a [5];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_pop0 = 0;

  logic [4:0]  s_ov;
  logic [4:0]  s_ir;
  logic [63:0] s_dout [5];

  logic [63:0] sb0[$], sb1[$], sb2[$], sb3[$], sb4[$];

  always #5 clk = ~clk;

  // Variants: 0 default, 1 dout=16, 2 dout=40, 3 NUM_STAGE=1, 4 NUM_STAGE=6.
  for (genvar g = 0; g < 5; g++) begin : g_dut
    localparam int WD = (g == 1) ? 16 : (g == 2) ? 40 : 32;
    localparam int NS = (g == 3) ? 1 : (g == 4) ? 6 : 3;
    logic [WD-1:0] d;
    logic          ir;
    logic          ov;

    knn_cluster1_mul_pipe #(
      .din0_WIDTH (17),
      .din1_WIDTH (15),
      .dout_WIDTH (WD),
      .NUM_STAGE  (NS)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (ir),
      .in_signed (in_signed),
      .din0      (din0),
      .din1      (din1),
      .out_valid (ov),
      .out_ready (out_ready),
      .dout      (d)
    );

    assign ir_v[g]   = ir;
    assign ov_v[g]   = ov;
    assign dout_a[g] = 64'(d);
  end

  function automatic int ns_of(int g);
    case (g)
      3:       return 1;
      4:       return 6;
      default: return 3;
    endcase
  endfunction

  function automatic int wd_of(int g);
    case (g)
      1:       return 16;
      2:       return 40;
      default: return 32;
    endcase
  endfunction

  // Exact integer product in 64 bits, then keep the low wd bits.
  function automatic logic [63:0] model(logic [16:0] a, logic [14:0] b, logic s, int wd);
    logic [63:0] xa, xb, full;
    xa   = s ? {{47{a[16]}}, a} : {47'd0, a};
    xb   = s ? {{49{b[14]}}, b} : {49'd0, b};
    full = xa * xb;
    if (wd < 64) full = full & ((64'd1 << wd) - 64'd1);
    return full;
  endfunction

  function automatic int sb_size(int g);
    case (g)
      0:       return sb0.size();
      1:       return sb1.size();
      2:       return sb2.size();
      3:       return sb3.size();
      default: return sb4.size();
    endcase
  endfunction

  task automatic sb_push(int g, logic [63:0] v);
    case (g)
      0:       sb0.push_back(v);
      1:       sb1.push_back(v);
      2:       sb2.push_back(v);
      3:       sb3.push_back(v);
      default: sb4.push_back(v);
    endcase
  endtask

  task automatic sb_pop(int g, output logic [63:0] v);
    case (g)
      0:       v = sb0.pop_front();
      1:       v = sb1.pop_front();
      2:       v = sb2.pop_front();
      3:       v = sb3.pop_front();
      default: v = sb4.pop_front();
    endcase
  endtask

  task automatic sb_flush();
    sb0.delete();
    sb1.delete();
    sb2.delete();
    sb3.delete();
    sb4.delete();
  endtask

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called right after a falling edge with inputs already driven; samples 1 ns later.
  task automatic cycle();
    logic [63:0] e;
    int          occ;
    #1;
    s_ov = ov_v;
    s_ir = ir_v;
    for (int g = 0; g < 5; g++) s_dout[g] = dout_a[g];
    if (reset) begin
      sb_flush();
    end else begin
      for (int g = 0; g < 5; g++) begin
        occ = sb_size(g);
        check($sformatf("in_ready[%0d]", g), 64'(ir_v[g]),
              64'((occ < ns_of(g)) || out_ready));
        if (occ == 0)
          check($sformatf("idle_out_valid[%0d]", g), 64'(ov_v[g]), 64'd0);
        if (ov_v[g] && out_ready && occ > 0) begin
          sb_pop(g, e);
          check($sformatf("dout[%0d]", g), dout_a[g], e);
          if (g == 0) last_pop0 = cyc;
        end
        if (in_valid && ir_v[g])
          sb_push(g, model(din0, din1, in_signed, wd_of(g)));
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (n) cycle();
  endtask

  // One isolated beat on an empty pipe: result visible after edge N+2, for exactly one cycle.
  task automatic pulse_test(string tag, logic [16:0] a, logic [14:0] b, logic s,
                            logic [63:0] e32, logic [63:0] e16, logic [63:0] e40);
    din0      = a;
    din1      = b;
    in_signed = s;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    cycle();
    check({tag, "_accept"}, 64'(s_ir[0]), 64'd1);
    in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cycle();
      check($sformatf("%s_ov_c%0d", tag, k), 64'(s_ov[0]), 64'(k == 3));
      if (k == 3) begin
        check({tag, "_dout32"}, s_dout[0], e32);
        check({tag, "_dout16"}, s_dout[1], e16);
        check({tag, "_dout40"}, s_dout[2], e40);
      end
    end
  endtask

  initial begin
    int          beats;
    int          c0;
    logic [63:0] held;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_signed = 1'b0;
    out_ready = 1'b1;
    din0      = '0;
    din1      = '0;
    @(negedge clk);
    repeat (3) cycle();
    reset = 1'b0;

    cycle();
    for (int g = 0; g < 5; g++) begin
      check($sformatf("reset_ov[%0d]", g), 64'(s_ov[g]), 64'd0);
      check($sformatf("reset_dout[%0d]", g), s_dout[g], 64'd0);
      check($sformatf("reset_in_ready[%0d]", g), 64'(s_ir[g]), 64'd1);
    end

    pulse_test("unsigned_max", 17'h1FFFF, 15'h7FFF, 1'b0,
               64'hFFFD8001, 64'h8001, 64'h00FFFD8001);
    idle(8);

    // Two signed beats back to back, results on consecutive cycles.
    in_signed = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    din0 = 17'h1FFFF; din1 = 15'h0003;
    cycle();
    din0 = 17'h10000; din1 = 15'h4000;
    cycle();
    in_valid = 1'b0;
    cycle();
    cycle();
    check("signed_first_ov", 64'(s_ov[0]), 64'd1);
    check("signed_neg1x3", s_dout[0], 64'hFFFFFFFD);
    check("signed_neg1x3_w16", s_dout[1], 64'hFFFD);
    check("signed_neg1x3_w40", s_dout[2], 64'hFFFFFFFFFD);
    cycle();
    check("signed_second_ov", 64'(s_ov[0]), 64'd1);
    check("signed_minxmin", s_dout[0], 64'h40000000);
    idle(8);

    // Ten-beat unsigned stream with out_ready low for cycles 4-9.
    beats     = 0;
    c0        = cyc;
    held      = '0;
    in_signed = 1'b0;
    for (int c = 0; c < 22; c++) begin
      in_valid  = (beats < 10);
      din0      = 17'(beats);
      din1      = 15'(beats + 1);
      out_ready = !(c >= 4 && c <= 9);
      cycle();
      if (c == 4) begin
        check("bp_accepts_before_stall", 64'(beats), 64'd4);
        check("bp_stall_ov", 64'(s_ov[0]), 64'd1);
        check("bp_stall_head", s_dout[0], 64'd2);
        held = s_dout[0];
      end
      if (c > 4 && c <= 9) begin
        check($sformatf("bp_hold_ov_c%0d", c), 64'(s_ov[0]), 64'd1);
        check($sformatf("bp_hold_dout_c%0d", c), s_dout[0], held);
      end
      if (in_valid && s_ir[0]) beats++;
    end
    check("bp_all_accepted", 64'(beats), 64'd10);
    check("bp_last_pop_cycle", 64'(last_pop0 - c0), 64'd18);
    idle(10);

    // Reset with three beats in flight.
    in_signed = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      din0     = 17'(c + 11);
      din1     = 15'(c + 3);
      cycle();
      check($sformatf("mid_accept_%0d", c), 64'(s_ir[0]), 64'd1);
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    cycle();
    reset = 1'b0;
    cycle();
    check("mid_reset_ov", 64'(s_ov[0]), 64'd0);
    check("mid_reset_dout", s_dout[0], 64'd0);
    check("mid_reset_in_ready", 64'(s_ir[0]), 64'd1);
    idle(8);
    pulse_test("fresh_5x7", 17'd5, 15'd7, 1'b0, 64'd35, 64'd35, 64'd35);
    idle(8);

    // Random sweep across all variants.
    for (int c = 0; c < 400; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_signed = 1'($urandom_range(0, 1));
      din0      = 17'($urandom);
      din1      = 15'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    idle(20);
    for (int g = 0; g < 5; g++)
      check($sformatf("drained[%0d]", g), 64'(sb_size(g)), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
